dm_dag: RTL and testbench
=========================

DM_DAG -- requirements
Module: dm_dag

Interface
REQ-001 SHALL have parameter DMA_SIZE, default 17, DM address width.
REQ-002 SHALL have parameter DMD_SIZE, default 16, DM data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ps_dg_req, input, 1, DM access request from the sequencer.
REQ-006 SHALL have port ps_dg_wrb, input, 1, access type: 1 = store, 0 = load.
REQ-007 SHALL have port ps_dg_pre, input, 1, modify mode: 1 = pre-modify, 0 = post-modify.
REQ-008 SHALL have port ps_dg_iadd, input, 3, I register select.
REQ-009 SHALL have port ps_dg_madd, input, 3, M register select.
REQ-010 SHALL have port ps_dg_st_dt, input, DMD_SIZE, store data.
REQ-011 SHALL have port ps_dg_ureg_wr, input, 1, DAG register write strobe.
REQ-012 SHALL have port ps_dg_ureg_sel, input, 5, register select: [4:3] 00=I, 01=M, 10=L, 11=B; [2:0] = index.
REQ-013 SHALL have port ps_dg_ureg_dt, input, DMA_SIZE, register write data.
REQ-014 SHALL have port dm_bc_dt, input, DMD_SIZE, read data returned by DM.
REQ-015 SHALL have port dg_dm_cslt, output, 1, DM chip select.
REQ-016 SHALL have port dg_dm_wrb, output, 1, DM write strobe.
REQ-017 SHALL have port dg_dm_add, output, DMA_SIZE, DM address.
REQ-018 SHALL have port dg_bc_dt, output, DMD_SIZE, store data to DM.
REQ-019 SHALL have port dg_ps_ld_dt, output, DMD_SIZE, load result.
REQ-020 SHALL have port dg_ps_ld_vld, output, 1, one-cycle load-result valid.

Function
REQ-021 SHALL hold eight I and eight M registers, each DMA_SIZE bits wide; all arithmetic SHALL be modulo 2^DMA_SIZE, with M treated as two's complement.
REQ-022 SHALL compute the effective address as I+M for pre-modify (I unchanged) and as I for post-modify (I <= I+M at the request edge).
REQ-023 SHALL, on the edge that samples ps_dg_req=1 (edge E0), register dg_dm_cslt=1, dg_dm_wrb=ps_dg_wrb and dg_dm_add=effective address, all valid during the next cycle.
REQ-024 SHALL drive dg_dm_cslt=0 in any cycle following an edge with ps_dg_req=0; dg_dm_add and dg_dm_wrb hold their last values.
REQ-025 SHALL, for a store, register ps_dg_st_dt at E0, then drive it on dg_bc_dt at E1 and hold it until E2, because DM writes one cycle after its address phase.
REQ-026 SHALL, for a load, capture dm_bc_dt at E2 into dg_ps_ld_dt and pulse dg_ps_ld_vld high for exactly the cycle after E2; load latency is 2 cycles from the request edge.
REQ-027 SHALL accept one request per cycle with no stall; back-to-back stores and loads pipeline fully.
REQ-028 SHALL make a ureg write visible to requests sampled on the following edge; a request in the same cycle uses the old value.
REQ-029 SHALL, when a ureg write and a post-modify target the same I in the same cycle, give the ureg write priority for the final I value.
REQ-030 SHALL write a load-after-store to the same address in consecutive cycles unchanged; correct data is supplied by DM bypass.

Reset
REQ-031 SHALL, while reset=0, clear all I/M/L/B registers and all outputs (dg_dm_cslt, dg_dm_wrb, dg_dm_add, dg_bc_dt, dg_ps_ld_dt, dg_ps_ld_vld) to 0.
REQ-032 SHALL, on reset asserted mid-operation, abandon all in-flight operations: no ld_vld pulse, and dg_bc_dt forced to 0.

Configuration
REQ-033 SHALL, with macro DAG_CIRC_EN defined, add eight L and eight B registers and apply circular wrap to both the pre-modify address and the post-modify update whenever L[n]!=0: if result < B, add L; if result >= B+L, subtract L. L=0 means linear.
REQ-034 SHALL, with DAG_CIRC_EN undefined, omit L/B, ignore ureg writes with sel[4]=1, and use linear modulo arithmetic only.

Verification (DMA_SIZE=17, DMD_SIZE=16)
REQ-035 Post-modify store: I0=0x00010, M0=1, st_dt=0xffee -> cslt=1, wrb=1, add=0x00010 next cycle; dg_bc_dt=0xffee the cycle after; I0 becomes 0x00011.
REQ-036 Pre-modify load: I1=0x0000a, M1=5, DM[0x0000f]=0x1234 -> add=0x0000f, I1 unchanged; ld_vld=1 with ld_dt=0x1234 two cycles after the request edge.
REQ-037 Wrap: M2=0x1ffff (-1) with I2=0 -> add=0 and I2 becomes 0x1ffff; with DAG_CIRC_EN, B2=0x100, L2=8, I2=0x107, M2=1 -> I2 becomes 0x100.
REQ-038 Same-cycle conflict: ureg write I3=0x00050 together with a post-modify request on I3=0x00020, M=2 -> add=0x00020, final I3=0x00050.
REQ-039 Reset mid-load: assert reset one cycle after a load request -> outputs 0, no ld_vld pulse.

Source files
------------

// File: rtl/dm_dag.sv
// ---------------------------------------------------------------------------
// dm_dag : data-memory address generator.
//
// Holds eight index (I) and eight modify (M) registers.  Each request
// produces a DM address, either I+M (pre-modify) or I (post-modify, with
// I <= I+M).  The block also sequences the store-data and load-data phases
// around the DM access.
//
// Optional feature, enabled with the macro DAG_CIRC_EN:
//   adds eight length (L) and eight base (B) registers and circular
//   addressing.  With the macro undefined, ureg writes to L/B are dropped
//   and all address arithmetic is linear modulo 2^DMA_SIZE.
//
// Ports
//   clk, reset (async, active low)
//   ps_dg_req / ps_dg_wrb / ps_dg_pre / ps_dg_iadd / ps_dg_madd / ps_dg_st_dt
//       : access request from the sequencer
//   ps_dg_ureg_wr / ps_dg_ureg_sel / ps_dg_ureg_dt
//       : DAG register write (sel[4:3] 00=I 01=M 10=L 11=B, sel[2:0]=index)
//   dm_bc_dt       : DM read data
//   dg_dm_cslt / dg_dm_wrb / dg_dm_add : DM address phase
//   dg_bc_dt       : store data to DM, driven one cycle after the address phase
//   dg_ps_ld_dt / dg_ps_ld_vld : load result, two cycles after the request edge
// ---------------------------------------------------------------------------
module dm_dag #(
   parameter int DMA_SIZE = 17,
   parameter int DMD_SIZE = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ps_dg_req,
   input  logic                ps_dg_wrb,
   input  logic                ps_dg_pre,
   input  logic [2:0]          ps_dg_iadd,
   input  logic [2:0]          ps_dg_madd,
   input  logic [DMD_SIZE-1:0] ps_dg_st_dt,
   input  logic                ps_dg_ureg_wr,
   input  logic [4:0]          ps_dg_ureg_sel,
   input  logic [DMA_SIZE-1:0] ps_dg_ureg_dt,
   input  logic [DMD_SIZE-1:0] dm_bc_dt,
   output logic                dg_dm_cslt,
   output logic                dg_dm_wrb,
   output logic [DMA_SIZE-1:0] dg_dm_add,
   output logic [DMD_SIZE-1:0] dg_bc_dt,
   output logic [DMD_SIZE-1:0] dg_ps_ld_dt,
   output logic                dg_ps_ld_vld
);

   logic [DMA_SIZE-1:0] i_reg [8];
   logic [DMA_SIZE-1:0] m_reg [8];
`ifdef DAG_CIRC_EN
   logic [DMA_SIZE-1:0] l_reg [8];
   logic [DMA_SIZE-1:0] b_reg [8];

   // Fold an address back into [B, B+L) when L is non-zero.  The upper bound
   // is formed one bit wider so a buffer that ends at the top of the address
   // space still compares correctly.
   function automatic logic [DMA_SIZE-1:0] circ_wrap(
      input logic [DMA_SIZE-1:0] v,
      input logic [DMA_SIZE-1:0] b,
      input logic [DMA_SIZE-1:0] l
   );
      logic [DMA_SIZE:0] top;
      top       = {1'b0, b} + {1'b0, l};
      circ_wrap = v;
      if (l != '0) begin
         if (v < b)
            circ_wrap = v + l;
         else if ({1'b0, v} >= top)
            circ_wrap = v - l;
      end
   endfunction
`endif

   logic [DMA_SIZE-1:0] sum_im;
   logic [DMA_SIZE-1:0] i_next;
   logic [DMA_SIZE-1:0] eff_add;

   // store/load pipeline tracking
   logic [DMD_SIZE-1:0] st_dt_q;
   logic                st_pend;
   logic                ld_p1;
   logic                ld_p2;

   always_comb begin
      sum_im = i_reg[ps_dg_iadd] + m_reg[ps_dg_madd];
`ifdef DAG_CIRC_EN
      i_next = circ_wrap(sum_im, b_reg[ps_dg_iadd], l_reg[ps_dg_iadd]);
`else
      i_next = sum_im;
`endif
      eff_add = ps_dg_pre ? i_next : i_reg[ps_dg_iadd];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int n = 0; n < 8; n++) begin
            i_reg[n] <= '0;
            m_reg[n] <= '0;
`ifdef DAG_CIRC_EN
            l_reg[n] <= '0;
            b_reg[n] <= '0;
`endif
         end
         dg_dm_cslt   <= 1'b0;
         dg_dm_wrb    <= 1'b0;
         dg_dm_add    <= '0;
         dg_bc_dt     <= '0;
         dg_ps_ld_dt  <= '0;
         dg_ps_ld_vld <= 1'b0;
         st_dt_q      <= '0;
         st_pend      <= 1'b0;
         ld_p1        <= 1'b0;
         ld_p2        <= 1'b0;
      end else begin
         dg_dm_cslt <= ps_dg_req;
         st_pend    <= ps_dg_req & ps_dg_wrb;
         ld_p1      <= ps_dg_req & ~ps_dg_wrb;
         ld_p2      <= ld_p1;

         if (ps_dg_req) begin
            dg_dm_wrb <= ps_dg_wrb;
            dg_dm_add <= eff_add;
            if (ps_dg_wrb)
               st_dt_q <= ps_dg_st_dt;
            if (!ps_dg_pre)
               i_reg[ps_dg_iadd] <= i_next;
         end

         // DM writes one cycle after its address phase
         if (st_pend)
            dg_bc_dt <= st_dt_q;

         dg_ps_ld_vld <= ld_p2;
         if (ld_p2)
            dg_ps_ld_dt <= dm_bc_dt;

         // Placed after the post-modify update so a same-cycle ureg write
         // to the same I register wins.
         if (ps_dg_ureg_wr) begin
            case (ps_dg_ureg_sel[4:3])
               2'b00: i_reg[ps_dg_ureg_sel[2:0]] <= ps_dg_ureg_dt;
               2'b01: m_reg[ps_dg_ureg_sel[2:0]] <= ps_dg_ureg_dt;
`ifdef DAG_CIRC_EN
               2'b10: l_reg[ps_dg_ureg_sel[2:0]] <= ps_dg_ureg_dt;
               2'b11: b_reg[ps_dg_ureg_sel[2:0]] <= ps_dg_ureg_dt;
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dm_dag.sv
module tb_dm_dag;
   localparam int AW = 17;
   localparam int DW = 16;
   localparam int unsigned AMASK = 32'h1ffff;
   localparam int HN = 2048;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ps_dg_req = 1'b0;
   logic          ps_dg_wrb = 1'b0;
   logic          ps_dg_pre = 1'b0;
   logic [2:0]    ps_dg_iadd = '0;
   logic [2:0]    ps_dg_madd = '0;
   logic [DW-1:0] ps_dg_st_dt = '0;
   logic          ps_dg_ureg_wr = 1'b0;
   logic [4:0]    ps_dg_ureg_sel = '0;
   logic [AW-1:0] ps_dg_ureg_dt = '0;
   logic [DW-1:0] dm_bc_dt = '0;
   logic          dg_dm_cslt;
   logic          dg_dm_wrb;
   logic [AW-1:0] dg_dm_add;
   logic [DW-1:0] dg_bc_dt;
   logic [DW-1:0] dg_ps_ld_dt;
   logic          dg_ps_ld_vld;

   dm_dag #(.DMA_SIZE(AW), .DMD_SIZE(DW)) dut (
      .clk(clk), .reset(reset),
      .ps_dg_req(ps_dg_req), .ps_dg_wrb(ps_dg_wrb), .ps_dg_pre(ps_dg_pre),
      .ps_dg_iadd(ps_dg_iadd), .ps_dg_madd(ps_dg_madd), .ps_dg_st_dt(ps_dg_st_dt),
      .ps_dg_ureg_wr(ps_dg_ureg_wr), .ps_dg_ureg_sel(ps_dg_ureg_sel),
      .ps_dg_ureg_dt(ps_dg_ureg_dt), .dm_bc_dt(dm_bc_dt),
      .dg_dm_cslt(dg_dm_cslt), .dg_dm_wrb(dg_dm_wrb), .dg_dm_add(dg_dm_add),
      .dg_bc_dt(dg_bc_dt), .dg_ps_ld_dt(dg_ps_ld_dt), .dg_ps_ld_vld(dg_ps_ld_vld)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model: architectural registers, DM contents, per-cycle history
   int unsigned mi [8];
   int unsigned mm [8];
   int unsigned ml [8];
   int unsigned mb [8];
   int unsigned mem [int unsigned];
   bit          h_st [HN];
   bit          h_ld [HN];
   int unsigned h_sd [HN];
   int unsigned h_lv [HN];
   int          cyc;
   int unsigned exp_add, exp_wrb, exp_bc, exp_ld;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned wrap(input int unsigned v_in, input int n);
      int unsigned v;
      v = v_in & AMASK;
`ifdef DAG_CIRC_EN
      if (ml[n] != 0) begin
         if (v < mb[n])
            v = (v + ml[n]) & AMASK;
         else if (v >= mb[n] + ml[n])
            v = (v - ml[n]) & AMASK;
      end
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int n = 0; n < 8; n++) begin
         mi[n] = 0; mm[n] = 0; ml[n] = 0; mb[n] = 0;
      end
      for (int n = 0; n < HN; n++) begin
         h_st[n] = 0; h_ld[n] = 0; h_sd[n] = 0; h_lv[n] = 0;
      end
      mem.delete();
      cyc = 2;
      exp_add = 0; exp_wrb = 0; exp_bc = 0; exp_ld = 0;
   endtask

   // Applies the currently driven inputs for one clock edge and checks
   // every output against the model just after that edge.
   task automatic do_cycle();
      int          k;
      int          ia, ma;
      int unsigned nxt, ea;
      k  = cyc;
      ia = int'(ps_dg_iadd);
      ma = int'(ps_dg_madd);
      h_st[k] = ps_dg_req && ps_dg_wrb;
      h_ld[k] = ps_dg_req && !ps_dg_wrb;
      h_sd[k] = ps_dg_st_dt;
      if (ps_dg_req) begin
         nxt = wrap(mi[ia] + mm[ma], ia);
         ea  = ps_dg_pre ? nxt : mi[ia];
         exp_add = ea;
         exp_wrb = ps_dg_wrb;
         if (!ps_dg_pre) mi[ia] = nxt;
         if (ps_dg_wrb) mem[ea] = ps_dg_st_dt;
         else h_lv[k] = mem.exists(ea) ? mem[ea] : (((ea * 7) ^ 32'h5a5a) & 32'hffff);
      end
      if (ps_dg_ureg_wr) begin
         case (ps_dg_ureg_sel[4:3])
            2'b00: mi[ps_dg_ureg_sel[2:0]] = ps_dg_ureg_dt & AMASK;
            2'b01: mm[ps_dg_ureg_sel[2:0]] = ps_dg_ureg_dt & AMASK;
`ifdef DAG_CIRC_EN
            2'b10: ml[ps_dg_ureg_sel[2:0]] = ps_dg_ureg_dt & AMASK;
            2'b11: mb[ps_dg_ureg_sel[2:0]] = ps_dg_ureg_dt & AMASK;
`endif
            default: ;
         endcase
      end
      // DM returns the addressed word only in the cycle the DAG captures it
      dm_bc_dt = h_ld[k-2] ? DW'(h_lv[k-2]) : DW'($urandom);
      @(posedge clk);
      #1;
      chk("cslt", 32'(dg_dm_cslt), 32'(ps_dg_req));
      chk("add", 32'(dg_dm_add), exp_add);
      chk("wrb", 32'(dg_dm_wrb), exp_wrb);
      if (h_st[k-1]) exp_bc = h_sd[k-1];
      chk("bc_dt", 32'(dg_bc_dt), exp_bc);
      chk("ld_vld", 32'(dg_ps_ld_vld), 32'(h_ld[k-2]));
      if (h_ld[k-2]) exp_ld = h_lv[k-2];
      chk("ld_dt", 32'(dg_ps_ld_dt), exp_ld);
      cyc++;
   endtask

   task automatic idle();
      ps_dg_req = 0; ps_dg_ureg_wr = 0;
      do_cycle();
   endtask

   task automatic ureg(input logic [4:0] sel, input logic [AW-1:0] dt);
      ps_dg_req = 0; ps_dg_ureg_wr = 1; ps_dg_ureg_sel = sel; ps_dg_ureg_dt = dt;
      do_cycle();
      ps_dg_ureg_wr = 0;
   endtask

   task automatic access(input logic wrb, input logic pre, input logic [2:0] ia,
                         input logic [2:0] ma, input logic [DW-1:0] st);
      ps_dg_req = 1; ps_dg_wrb = wrb; ps_dg_pre = pre;
      ps_dg_iadd = ia; ps_dg_madd = ma; ps_dg_st_dt = st;
      do_cycle();
      ps_dg_req = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cslt"}, 32'(dg_dm_cslt), 0);
      chk({tag, "_wrb"}, 32'(dg_dm_wrb), 0);
      chk({tag, "_add"}, 32'(dg_dm_add), 0);
      chk({tag, "_bc"}, 32'(dg_bc_dt), 0);
      chk({tag, "_lddt"}, 32'(dg_ps_ld_dt), 0);
      chk({tag, "_ldvld"}, 32'(dg_ps_ld_vld), 0);
   endtask

   task automatic random_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         ps_dg_req      = ($urandom % 4) != 0;
         ps_dg_wrb      = $urandom % 2;
         ps_dg_pre      = $urandom % 2;
         ps_dg_iadd     = 3'($urandom);
         ps_dg_madd     = 3'($urandom);
         ps_dg_st_dt    = DW'($urandom);
         ps_dg_ureg_wr  = ($urandom % 4) == 0;
         ps_dg_ureg_sel = 5'($urandom);
         ps_dg_ureg_dt  = (($urandom % 8) == 0) ? AW'($urandom) : AW'($urandom % 64);
         do_cycle();
      end
      ps_dg_req = 0; ps_dg_ureg_wr = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      // reset state
      @(posedge clk); #1;
      chk_all_zero("reset");
      reset = 1;
      idle();

      // post-modify store
      ureg(5'b00_000, 17'h00010);
      ureg(5'b01_000, 17'h00001);
      access(1, 0, 0, 0, 16'hffee);
      chk("s_add", 32'(dg_dm_add), 32'h10);
      chk("s_cslt", 32'(dg_dm_cslt), 1);
      chk("s_wrb", 32'(dg_dm_wrb), 1);
      idle();
      chk("s_bcdt", 32'(dg_bc_dt), 32'hffee);
      access(0, 0, 0, 0, 0);
      chk("s_i0", 32'(dg_dm_add), 32'h11);

      // pre-modify load
      mem[17'h0000f] = 16'h1234;
      ureg(5'b00_001, 17'h0000a);
      ureg(5'b01_001, 17'h00005);
      access(0, 1, 1, 1, 0);
      chk("l_add", 32'(dg_dm_add), 32'hf);
      chk("l_vld_e1", 32'(dg_ps_ld_vld), 0);
      idle();
      chk("l_vld_e2", 32'(dg_ps_ld_vld), 0);
      idle();
      chk("l_vld", 32'(dg_ps_ld_vld), 1);
      chk("l_dt", 32'(dg_ps_ld_dt), 32'h1234);
      idle();
      chk("l_vld_off", 32'(dg_ps_ld_vld), 0);
      access(0, 0, 1, 1, 0);
      chk("l_i1", 32'(dg_dm_add), 32'ha);

      // linear wrap
      ureg(5'b00_010, 17'h00000);
      ureg(5'b01_010, 17'h1ffff);
      access(1, 0, 2, 2, 16'h0101);
      chk("w_add", 32'(dg_dm_add), 0);
      access(1, 0, 2, 2, 16'h0202);
      chk("w_i2", 32'(dg_dm_add), 32'h1ffff);
`ifdef DAG_CIRC_EN
      ureg(5'b11_010, 17'h00100);
      ureg(5'b10_010, 17'h00008);
      ureg(5'b00_010, 17'h00107);
      ureg(5'b01_010, 17'h00001);
      access(0, 0, 2, 2, 0);
      chk("c_add", 32'(dg_dm_add), 32'h107);
      access(0, 0, 2, 2, 0);
      chk("c_i2", 32'(dg_dm_add), 32'h100);
`else
      // L/B writes must be ignored: I2 still steps linearly
      ureg(5'b10_010, 17'h00008);
      ureg(5'b00_010, 17'h00107);
      ureg(5'b01_010, 17'h00001);
      access(0, 0, 2, 2, 0);
      access(0, 0, 2, 2, 0);
      chk("c_i2_lin", 32'(dg_dm_add), 32'h108);
`endif

      // ureg write vs post-modify on the same I
      ureg(5'b00_011, 17'h00020);
      ureg(5'b01_011, 17'h00002);
      ps_dg_ureg_wr = 1; ps_dg_ureg_sel = 5'b00_011; ps_dg_ureg_dt = 17'h00050;
      access(0, 0, 3, 3, 0);
      ps_dg_ureg_wr = 0;
      chk("x_add", 32'(dg_dm_add), 32'h20);
      access(0, 0, 3, 3, 0);
      chk("x_i3", 32'(dg_dm_add), 32'h50);

      // store followed by load of the same address
      ureg(5'b00_100, 17'h00200);
      ureg(5'b01_100, 17'h00000);
      access(1, 0, 4, 4, 16'hbeef);
      access(0, 0, 4, 4, 0);
      idle();
      idle();
      chk("sl_dt", 32'(dg_ps_ld_dt), 32'hbeef);

      random_cycles(400);
      idle(); idle(); idle();

      // reset one cycle after a load request
      access(0, 0, 1, 1, 0);
      reset = 0;
      #1;
      chk_all_zero("rmid");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rmid_vld", 32'(dg_ps_ld_vld), 0);
      end
      chk_all_zero("rhold");
      reset = 1;
      model_reset();
      random_cycles(150);
      idle(); idle(); idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
